// File: rtl/alu_sequencer.sv
// Instruction sequencer: buffers 16-bit instructions in a FIFO, issues them one at a
// time to an external ALU, and writes results back into a four-entry register file.
module alu_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        go,
    input  logic        clr_flags,
    output logic [15:0] alu_instruction,
    output logic [7:0]  alu_data0,
    output logic [7:0]  alu_data1,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic [7:0]  result,
    output logic [1:0]  result_dest,
    output logic        result_valid,
    output logic        zero_flag,
    output logic        ovf_sticky,
    output logic        busy,
    output logic        halted
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t         r_state;
    logic [15:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [7:0]     r_regs [4];
    logic [LW-1:0]  r_lat_cnt;

    logic           r_instr_ready;
    logic [15:0]    r_alu_instruction;
    logic [7:0]     r_alu_data0;
    logic [7:0]     r_alu_data1;
    logic [7:0]     r_result;
    logic [1:0]     r_result_dest;
    logic           r_result_valid;
    logic           r_zero_flag;
    logic           r_ovf_sticky;
    logic           r_busy;
    logic           r_halted;

    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_count_nxt;
    logic [15:0]    w_head;
    logic [1:0]     w_mode;
    logic [7:0]     w_imm;
    logic [7:0]     w_src_a;
    logic [7:0]     w_src_b;
    logic [1:0]     w_wb_dest;

    // Pop only from IDLE, so operand reads always see the previous write-back.
    assign w_push      = instr_valid && r_instr_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_mode      = w_head[9:8];
    assign w_imm       = w_head[7:0];
    assign w_src_a     = r_regs[w_head[13:12]];
    assign w_src_b     = (w_mode == 2'b00) ? w_imm : r_regs[w_imm[1:0]];
    assign w_wb_dest   = r_alu_instruction[11:10];

    assign instr_ready     = r_instr_ready;
    assign alu_instruction = r_alu_instruction;
    assign alu_data0       = r_alu_data0;
    assign alu_data1       = r_alu_data1;
    assign result          = r_result;
    assign result_dest     = r_result_dest;
    assign result_valid    = r_result_valid;
    assign zero_flag       = r_zero_flag;
    assign ovf_sticky      = r_ovf_sticky;
    assign busy            = r_busy;
    assign halted          = r_halted;

    // FIFO storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            r_lat_cnt         <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_instr_ready     <= 1'b1;
            r_alu_instruction <= '0;
            r_alu_data0       <= '0;
            r_alu_data1       <= '0;
            r_result          <= '0;
            r_result_dest     <= '0;
            r_result_valid    <= 1'b0;
            r_zero_flag       <= 1'b0;
            r_ovf_sticky      <= 1'b0;
            r_busy            <= 1'b0;
            r_halted          <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_instr_ready <= (w_count_nxt != CW'(DEPTH));
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            if (clr_flags) begin
                r_ovf_sticky <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_mode == 2'b10) begin
                            r_state  <= S_HALT;
                            r_busy   <= 1'b1;
                            r_halted <= 1'b1;
                        end else if (w_mode != 2'b11) begin
                            r_alu_instruction <= w_head;
                            r_alu_data0       <= w_src_a;
                            r_alu_data1       <= w_src_b;
                            r_lat_cnt         <= LW'(ALU_LAT - 1);
                            r_state           <= S_EXEC;
                            r_busy            <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_lat_cnt == '0) begin
                        r_regs[w_wb_dest] <= alu_result;
                        r_result          <= alu_result;
                        r_result_dest     <= w_wb_dest;
                        r_zero_flag       <= alu_zero;
                        // A coincident overflow outranks clr_flags.
                        if (alu_overflow) begin
                            r_ovf_sticky <= 1'b1;
                        end
                        r_result_valid    <= 1'b1;
                        r_state           <= S_WB;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end
                end
                S_WB: begin
                    r_result_valid <= 1'b0;
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                end
                S_HALT: begin
                    if (go) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, 4, instruction FIFO entries (power of two).
REQ-002 Parameter ALU_LAT, 1, cycles from ALU operand launch to valid alu_result/flags (1..7).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr_in  input  16  instruction: [15:14] op, [13:12] srcA reg, [11:10] dest reg, [9:8] mode, [7:0] imm.
REQ-006 instr_valid  input  1  host push request; instr_ready  output  1  FIFO not full.
REQ-007 go  input  1  single-cycle pulse releasing HALT; clr_flags  input  1  clears sticky flags.
REQ-008 alu_instruction  output  16  registered copy of issued instruction to the ALU.
REQ-009 alu_data0, alu_data1  output  8 each  registered ALU operands.
REQ-010 alu_result  input  8; alu_zero  input  1; alu_overflow  input  1  ALU response.
REQ-011 result  output  8; result_dest  output  2; result_valid  output  1  write-back report.
REQ-012 zero_flag  output  1  last write-back zero; ovf_sticky  output  1  OR of overflows since clear.
REQ-013 busy  output  1  high in any state except IDLE; halted  output  1  high in HALT.

Function
REQ-014 FIFO push SHALL occur when instr_valid && instr_ready; instr_ready = !full, no same-cycle bypass when full even if a pop occurs.
REQ-015 Register file: four 8-bit registers r0..r3, written only in write-back.
REQ-016 States SHALL be IDLE, EXEC, WB, HALT.
REQ-017 IDLE, FIFO non-empty: at edge pop head; mode 10 -> HALT (ALU outputs unchanged); else load alu_instruction=head, alu_data0=r[srcA], alu_data1 = imm (mode 00) or r[imm[1:0]] (mode 01), go EXEC.
REQ-018 Mode 11 SHALL be popped and discarded as NOP, staying IDLE, no result_valid.
REQ-019 EXEC SHALL last exactly ALU_LAT cycles (internal down-counter); at the edge ending the last EXEC cycle capture alu_result into r[dest] and result, alu_zero into zero_flag, OR alu_overflow into ovf_sticky; go WB.
REQ-020 WB SHALL last one cycle with result_valid=1, result_dest=dest; then IDLE; result_valid low in every other state.
REQ-021 Latency: pop edge t -> result_valid high in cycle t+ALU_LAT+1; throughput one instruction per ALU_LAT+2 cycles.
REQ-022 HALT SHALL hold until go=1 sampled at an edge, then IDLE; go outside HALT ignored; FIFO keeps accepting pushes in HALT.
REQ-023 alu_* outputs SHALL remain stable from EXEC entry until next issue.
REQ-024 clr_flags SHALL clear ovf_sticky; if coincident with a write-back overflow, set wins.
REQ-025 Register operand reads SHALL see the prior instruction's write-back (no hazard: issue only from IDLE).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; count DEPTH+1 wide; empty FIFO leaves IDLE idle.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, empty FIFO, r0..r3=0, all outputs 0 except instr_ready=1.
REQ-028 Reset mid-EXEC/WB SHALL abort the instruction: no register write, no result_valid after release.
REQ-029 First push accepted on the first rising edge after rst_n rises.

Verification (bench ALU model: op 00 add, result=data0+data1, overflow=carry, zero=(result==0); ALU_LAT=1)
REQ-030 Push 16'b00_00_01_00_00000101 after reset -> alu_data0=0, alu_data1=5 in EXEC; result_valid one cycle with result=5, result_dest=1, zero_flag=0, pop-to-valid 2 cycles.
REQ-031 Push r0=0+255 -> r0 (imm FF, dest 0), then r0+imm 1 -> r0 -> second result=0, zero_flag=1, ovf_sticky=1; pulse clr_flags -> ovf_sticky=0.
REQ-032 Push mode 01 instr srcA=r1, imm[1:0]=1 after REQ-030 -> alu_data0=5, alu_data1=5, result=10.
REQ-033 Push halt (mode 10) then 5 more back-to-back -> halted=1, 4 accepted, instr_ready=0 on 5th; go pulse -> 4 instructions execute in order, 4 result_valid pulses 3 cycles apart.
REQ-034 Drop rst_n for one cycle during EXEC -> all outputs 0 at once, no result_valid, FIFO empty, instr_ready=1.
REQ-035 Push mode 11 NOP -> popped, busy stays 0, no ALU output change, no result_valid.
